// File: rtl/chan_block_buf_pkg.sv
// Shared definitions for the channel block buffer: default geometry,
// arbiter K-codes, block header layout, RAM word format and write-side states.
package chan_block_buf_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

  // Arbiter link K-codes
  localparam logic [15:0] K_COMMA = 16'h00BC;
  localparam logic [15:0] K_TRIG  = 16'h801C;

  // First word of every block produced by the channel block builder
  typedef struct packed {
    logic [3:0]  chan_id;
    logic [11:0] blk_len;
  } blk_hdr_t;

  // One buffer entry: data word plus end-of-block flag
  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } buf_word_t;

  // Write side: accepting words, or discarding the rest of an aborted block
  typedef enum logic {
    WR_ACCEPT  = 1'b0,
    WR_DISCARD = 1'b1
  } wr_state_t;

endpackage

// File: rtl/chan_buf_ram.sv
// Simple dual-port RAM, one write port and one synchronous-read port.
// Ports:
//   clk          system clock
//   we/waddr/wdata  write port
//   re/raddr     read enable and address; rdata updates only when re=1
//   rdata        registered read data
module chan_buf_ram
  import chan_block_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  buf_word_t         wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output buf_word_t         rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  buf_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/chan_block_buf.sv
// Block-granular circular buffer between the channel block builder and one
// 16-bit lane of the arbiter bus. Only complete blocks are exposed to the
// reader; a block that overflows the buffer is discarded as a whole.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   din/din_we/din_last  block words in; din_last marks the final word
//   dout/req/ack      head word, request (a complete block is ready), consume
//   drop/drop_cnt     overflow pulse and saturating count of dropped blocks
//   blk_cnt           complete blocks currently held
module chan_block_buf
  import chan_block_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       din,
  input  logic              din_we,
  input  logic              din_last,
  output logic [15:0]       dout,
  output logic              req,
  input  logic              ack,
  output logic              drop,
  output logic [15:0]       drop_cnt,
  output logic [ADDR_W:0]   blk_cnt
);

  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Pointers carry one extra bit so full and empty are distinguishable.
  //   rd_ptr    : word currently in dout
  //   iss_ptr   : next word to read out of the RAM
  //   blk_start : end of committed data / start of the block being written
  //   wr_ptr    : next write location
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] blk_start;
  logic [PW-1:0] iss_ptr;
  logic [PW-1:0] rd_ptr;
  wr_state_t     wr_state;
  logic          s1_vld;      // RAM read register holds a word not yet in dout
  logic          dout_last;
  buf_word_t     ram_q;
  buf_word_t     ram_wdata_c;

  logic [PW-1:0] used_c;
  logic          full_c;
  logic          pop_c;
  logic          s2_load_c;
  logic          issue_c;
  logic          abort_c;
  logic          accept_c;
  logic          commit_c;
  logic          pop_last_c;

  assign used_c      = wr_ptr - rd_ptr;
  assign full_c      = (used_c == PW'(DEPTH));
  assign pop_c       = ack && req;
  // req doubles as the dout-valid flag: dout only ever holds committed words.
  assign s2_load_c   = s1_vld && (!req || pop_c);
  assign issue_c     = (iss_ptr != blk_start) && (!s1_vld || s2_load_c);
  assign abort_c     = din_we && (wr_state == WR_ACCEPT) && full_c;
  assign accept_c    = din_we && (wr_state == WR_ACCEPT) && !full_c;
  assign commit_c    = accept_c && din_last;
  assign pop_last_c  = pop_c && dout_last;
  assign ram_wdata_c = '{last: din_last, data: din};

  chan_buf_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (accept_c),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (ram_wdata_c),
    .re    (issue_c),
    .raddr (iss_ptr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  // Write-side state machine plus the two-stage read prefetch (RAM, dout)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state  <= WR_ACCEPT;
      wr_ptr    <= '0;
      blk_start <= '0;
      iss_ptr   <= '0;
      rd_ptr    <= '0;
      s1_vld    <= 1'b0;
      dout      <= 16'h0000;
      dout_last <= 1'b0;
      req       <= 1'b0;
      drop      <= 1'b0;
      drop_cnt  <= 16'h0000;
      blk_cnt   <= '0;
    end else begin
      drop <= 1'b0;

      case (wr_state)
        WR_ACCEPT: begin
          if (abort_c) begin
            // Rewind to the block start; committed words are untouched.
            wr_ptr <= blk_start;
            drop   <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
              drop_cnt <= drop_cnt + 16'd1;
            end
            if (!din_last) begin
              wr_state <= WR_DISCARD;
            end
          end else if (accept_c) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (din_last) begin
              blk_start <= wr_ptr + PW'(1);
            end
          end
        end
        WR_DISCARD: begin
          if (din_we && din_last) begin
            wr_state <= WR_ACCEPT;
          end
        end
        default: wr_state <= WR_ACCEPT;
      endcase

      if (issue_c) begin
        iss_ptr <= iss_ptr + PW'(1);
      end

      if (issue_c) begin
        s1_vld <= 1'b1;
      end else if (s2_load_c) begin
        s1_vld <= 1'b0;
      end

      if (s2_load_c) begin
        dout      <= ram_q.data;
        dout_last <= ram_q.last;
        req       <= 1'b1;
      end else if (pop_c) begin
        req <= 1'b0;
      end

      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      blk_cnt <= blk_cnt + PW'(commit_c) - PW'(pop_last_c);
    end
  end

endmodule

// File: doc/chan_block_buf.md
CHAN_BLOCK_BUF -- requirements
Module: chan_block_buf

Interface
REQ-001 Parameter ADDR_W, default 10: buffer depth DEPTH = 2^ADDR_W 16-bit words.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 din  in  16  block word from the channel block builder.
REQ-005 din_we  in  1  din valid this cycle.
REQ-006 din_last  in  1  qualifies din_we; marks the final word of a block.
REQ-007 dout  out  16  head word toward one 16-bit lane of the arbiter data bus.
REQ-008 req  out  1  at least one complete block is held; request to the arbiter.
REQ-009 ack  in  1  arbiter consumed dout this cycle.
REQ-010 drop  out  1  one-cycle pulse: a block was discarded on overflow.
REQ-011 drop_cnt  out  16  count of discarded blocks, saturating at 16'hFFFF.
REQ-012 blk_cnt  out  ADDR_W+1  complete blocks currently held.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH words plus one last-flag bit per word; pointers wrap modulo DEPTH.
REQ-014 A write is accepted on every edge with din_we=1 unless the block is being dropped (REQ-020..022).
REQ-015 A block is committed on the edge that accepts its din_last word; committed blocks only are visible to the read side.
REQ-016 req SHALL rise exactly 2 cycles after the edge committing a block into an otherwise empty buffer.
REQ-017 req SHALL be 1 iff blk_cnt != 0 and dout holds a valid head word.
REQ-018 On each edge with ack=1 and req=1: pop the head word; dout SHALL present the next word in the following cycle with no bubble, including across the wrap from DEPTH-1 to 0.
REQ-019 Popping a word with last-flag=1 decrements blk_cnt on that edge. If blk_cnt becomes 0, req SHALL be 0 in the next cycle so the arbiter advances. Otherwise req stays 1 and the next block follows back-to-back.
REQ-020 ack with req=0 SHALL be ignored: no pointer or count change.
REQ-021 Overflow: a write arriving while used words == DEPTH SHALL abort the current block:
  - write pointer returns to the block start;
  - drop pulses for 1 cycle;
  - drop_cnt increments (saturating).
REQ-022 After an abort, writes are discarded up to and including the next din_last; normal acceptance resumes on the following word.
REQ-023 A single block longer than DEPTH is always dropped and SHALL never be committed.
REQ-024 A simultaneous write and pop on one edge are both performed; used words is unchanged.
REQ-025 A pop on the same edge as an overflowing write SHALL NOT prevent the drop; the decision uses the pre-edge fill level.
REQ-026 Committed data SHALL never be modified by an abort.

Reset
REQ-027 reset=1 SHALL clear pointers, blk_cnt, drop_cnt, the drop-in-progress flag and drop, and set dout=16'h0000.
REQ-028 req SHALL be 0 in the cycle after any reset edge.
REQ-029 Reset asserted mid-block or mid-read SHALL discard all content; stored memory contents need not be cleared.

Structure
REQ-030 Shared package holds DEPTH/ADDR_W defaults, the arbiter K-codes (comma 16'h00BC, trigger 16'h801C) and the block header field layout.
REQ-031 One sub-module, chan_buf_ram: simple dual-port (ADDR_W x 17) synchronous-read RAM. All control logic lives in chan_block_buf.

Verification
REQ-032 Write one 4-word block A0..A3, then hold ack=1 whenever req=1 -> req rises 2 cycles after the commit edge; dout sequence A0..A3 on 4 consecutive acks; req=0 in the cycle after A3 is popped; blk_cnt goes 1 -> 0.
REQ-033 Write two 3-word blocks, then ack continuously -> 6 words with no gap; req stays 1 throughout; blk_cnt goes 2 -> 1 -> 0.
REQ-034 ADDR_W=4: fill 14 words, then write a 5-word block -> drop=1 once, drop_cnt=1; 14 prior words read back intact; next 3-word block is accepted.
REQ-035 Start the read pointer at 14 (ADDR_W=4) and write a 4-word block -> output is seamless across the wrap; data order is preserved.
REQ-036 Assert reset mid-read of an 8-word block after 3 pops -> req=0 the next cycle; blk_cnt=0; drop_cnt=0; a fresh block then reads correctly.
REQ-037 Pulse ack with req=0, and write a 20-word block with ADDR_W=4 -> no state change from the ack; the oversized block is dropped and req never rises.
